// File: rtl/interpfir_if.sv
// Streaming handshake bundle for interpfir: sample in (valid/ready), filtered samples out (valid/ready).
interface interpfir_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned OW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] data_in;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] data_out;

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out
    );

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out
    );
endinterface

// File: rtl/interpfir.sv
// Polyphase interpolating FIR: one multiplier, TPP MAC cycles per output, L outputs per input sample.
module interpfir #(
    parameter int unsigned L   = 4,
    parameter int unsigned TPP = 4,
    parameter int unsigned DW  = 8,
    parameter int unsigned OW  = 16
) (
    input  logic       clk,
    input  logic       rst,
    interpfir_if.slave bus
);
    localparam int unsigned PW = (L > 1) ? $clog2(L) : 1;
    localparam int unsigned JW = (TPP > 1) ? $clog2(TPP) : 1;

    typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;

    state_t                   state_q, state_d;
    logic [PW-1:0]            p_q, p_d;
    logic [JW-1:0]            j_q, j_d;
    logic [OW-1:0]            acc_q, acc_d;
    logic [TPP-1:0][DW-1:0]   x_q, x_d;
    logic                     out_valid_q, out_valid_d;
    logic [OW-1:0]            data_out_q, data_out_d;

    logic [31:0]              tap_num;
    logic [DW-1:0]            coef;
    logic [2*DW-1:0]          prod_full;
    logic [OW-1:0]            prod;

    // Coefficient h[k] = k+1 is generated from the tap index instead of stored.
    always_comb begin
        tap_num   = 32'(j_q) * L + 32'(p_q) + 32'd1;
        coef      = tap_num[DW-1:0];
        prod_full = coef * x_q[j_q];
        prod      = OW'(prod_full);
    end

    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        j_d         = j_q;
        acc_d       = acc_q;
        x_d         = x_q;
        out_valid_d = out_valid_q;
        data_out_d  = data_out_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    x_d[0] = bus.data_in;
                    for (int unsigned i = 1; i < TPP; i++) begin
                        x_d[i] = x_q[i-1];
                    end
                    p_d     = '0;
                    j_d     = '0;
                    acc_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                if (j_q == JW'(TPP - 1)) begin
                    data_out_d  = acc_q + prod;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    j_d         = '0;
                    state_d     = HOLD;
                end else begin
                    acc_d = acc_q + prod;
                    j_d   = j_q + 1'b1;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (p_q == PW'(L - 1)) begin
                        state_d = IDLE;
                    end else begin
                        p_d     = p_q + 1'b1;
                        state_d = MAC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            p_q         <= '0;
            j_q         <= '0;
            acc_q       <= '0;
            x_q         <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            j_q         <= j_d;
            acc_q       <= acc_d;
            x_q         <= x_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_out_q;
endmodule

// File: tb/tb_interpfir.sv
// Directed bench for interpfir: impulse, max DC, backpressure, mid-run reset and throughput.
module tb_interpfir;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    interpfir_if #(.DW(8), .OW(16)) bus ();

    interpfir #(.L(4), .TPP(4), .DW(8), .OW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [15:0] out_q[$];
    int          out_t[$];
    int          acc_t[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes seen at the negedge complete on the following posedge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                out_q.push_back(bus.data_out);
                out_t.push_back(cyc);
            end
            if (bus.in_valid && bus.in_ready) acc_t.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        out_q.delete();
        out_t.delete();
        acc_t.delete();
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic send(input logic [7:0] s);
        for (int i = 0; i < 100 && !bus.in_ready; i++) tick(1);
        bus.in_valid = 1'b1;
        bus.data_in  = s;
        tick(1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_outs(input int n, input int budget);
        for (int i = 0; i < budget && out_q.size() < n; i++) tick(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.data_in   = 8'($urandom);
            bus.out_ready = 1'($urandom_range(0, 1));
            tick(1);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_out_valid cyc%0d got=%b exp=0", c, bus.out_valid);
            end
            checks++;
            if (bus.data_out !== 16'd0) begin
                failures++;
                $display("FAIL reset_data_out cyc%0d got=%0d exp=0", c, bus.data_out);
            end
            checks++;
            if (bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL reset_in_ready cyc%0d got=%b exp=0", c, bus.in_ready);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_in_ready got=%b exp=1", bus.in_ready);
        end
        tick(1);
        clear_logs();
    endtask

    task automatic test_impulse();
        do_reset();
        bus.out_ready = 1'b1;
        send(8'd1);
        for (int i = 0; i < 4; i++) send(8'd0);
        wait_outs(20, 300);
        checks++;
        if (out_q.size() != 20) begin
            failures++;
            $display("FAIL impulse_count got=%0d exp=20", out_q.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                logic [15:0] exp_v;
                exp_v = (i < 16) ? 16'(i + 1) : 16'd0;
                checks++;
                if (out_q[i] !== exp_v) begin
                    failures++;
                    $display("FAIL impulse_value[%0d] got=%0d exp=%0d", i, out_q[i], exp_v);
                end
            end
            // Four phases at 5 cycles each, plus one IDLE cycle between inputs.
            for (int i = 1; i < 20; i++) begin
                int exp_d;
                exp_d = (i % 4 == 0) ? 6 : 5;
                checks++;
                if (out_t[i] - out_t[i-1] != exp_d) begin
                    failures++;
                    $display("FAIL impulse_spacing[%0d] got=%0d exp=%0d", i, out_t[i] - out_t[i-1], exp_d);
                end
            end
        end
    endtask

    task automatic test_max_dc();
        logic [15:0] exp_v[4];
        exp_v = '{16'd7140, 16'd8160, 16'd9180, 16'd10200};
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(8'd255);
        wait_outs(20, 300);
        checks++;
        if (out_q.size() != 20) begin
            failures++;
            $display("FAIL maxdc_count got=%0d exp=20", out_q.size());
        end else begin
            for (int p = 0; p < 4; p++) begin
                checks++;
                if (out_q[16+p] !== exp_v[p]) begin
                    failures++;
                    $display("FAIL maxdc_phase%0d got=%0d exp=%0d", p, out_q[16+p], exp_v[p]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_v[8];
        exp_v = '{16'd3, 16'd6, 16'd9, 16'd12, 16'd22, 16'd32, 16'd42, 16'd52};
        do_reset();
        send(8'd3);
        bus.in_valid = 1'b1;
        bus.data_in  = 8'd7;
        for (int i = 0; i < 20 && !bus.out_valid; i++) tick(1);
        for (int c = 0; c < 7; c++) begin
            checks++;
            if (bus.out_valid !== 1'b1) begin
                failures++;
                $display("FAIL bp_out_valid cyc%0d got=%b exp=1", c, bus.out_valid);
            end
            checks++;
            if (bus.data_out !== 16'd3) begin
                failures++;
                $display("FAIL bp_data_stable cyc%0d got=%0d exp=3", c, bus.data_out);
            end
            checks++;
            if (bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_in_ready cyc%0d got=%b exp=0", c, bus.in_ready);
            end
            tick(1);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100 && acc_t.size() < 2; i++) tick(1);
        bus.in_valid = 1'b0;
        wait_outs(8, 200);
        checks++;
        if (acc_t.size() != 2) begin
            failures++;
            $display("FAIL bp_accept_count got=%0d exp=2", acc_t.size());
        end
        checks++;
        if (out_q.size() != 8) begin
            failures++;
            $display("FAIL bp_out_count got=%0d exp=8", out_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (out_q[i] !== exp_v[i]) begin
                    failures++;
                    $display("FAIL bp_value[%0d] got=%0d exp=%0d", i, out_q[i], exp_v[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.out_ready = 1'b1;
        send(8'd5);
        for (int i = 0; i < 50 && out_q.size() < 2; i++) tick(1);
        tick(1);
        rst = 1'b1;
        tick(1);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.data_out !== 16'd0) begin
            failures++;
            $display("FAIL midrst_outputs got=%b/%0d exp=0/0", bus.out_valid, bus.data_out);
        end
        rst = 1'b0;
        clear_logs();
        send(8'd1);
        wait_outs(4, 100);
        tick(10);
        checks++;
        if (out_q.size() != 4) begin
            failures++;
            $display("FAIL midrst_count got=%0d exp=4", out_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (out_q[i] !== 16'(i + 1)) begin
                    failures++;
                    $display("FAIL midrst_value[%0d] got=%0d exp=%0d", i, out_q[i], i + 1);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_v[4];
        exp_v = '{16'd56, 16'd64, 16'd72, 16'd80};
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.data_in   = 8'd2;
        for (int i = 0; i < 200 && acc_t.size() < 4; i++) tick(1);
        bus.in_valid = 1'b0;
        wait_outs(16, 200);
        tick(30);
        checks++;
        if (acc_t.size() != 4) begin
            failures++;
            $display("FAIL b2b_accept_count got=%0d exp=4", acc_t.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (acc_t[i] - acc_t[i-1] != 21) begin
                    failures++;
                    $display("FAIL b2b_accept_spacing[%0d] got=%0d exp=21", i, acc_t[i] - acc_t[i-1]);
                end
            end
        end
        checks++;
        if (out_q.size() != 16) begin
            failures++;
            $display("FAIL b2b_out_count got=%0d exp=16", out_q.size());
        end else begin
            for (int p = 0; p < 4; p++) begin
                checks++;
                if (out_q[12+p] !== exp_v[p]) begin
                    failures++;
                    $display("FAIL b2b_value_phase%0d got=%0d exp=%0d", p, out_q[12+p], exp_v[p]);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_impulse();
        test_max_dc();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
